// File: rtl/apb_encoder.sv
// Response-side RAH packer: turns one command plus its byte stream into a header frame
// followed by 6-byte continuation frames, written one 48-bit word at a time into the TX FIFO.
module apb_encoder #(
    parameter int RAH_PACKET_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_cfg_sel,
    input  logic [6:0]                  cmd_slv_id,
    input  logic [7:0]                  cmd_length,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_byte,
    input  logic                        f_full,
    output logic                        wr_en,
    output logic [RAH_PACKET_WIDTH-1:0] w_data,
    output logic                        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_PUSH
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [RAH_PACKET_WIDTH-1:0] r_buf;
    logic [7:0]                  r_rem;
    logic [2:0]                  r_idx;
    logic [5:0]                  w_base;
    logic                        w_last_byte;

    // Header bytes start below the 16-bit command field; continuation bytes fill the whole word.
    assign w_base = (r_state == ST_HDR) ? (6'd31 - {r_idx, 3'b000})
                                        : (6'd47 - {r_idx, 3'b000});

    assign w_last_byte = (r_rem == 8'd1) ||
                         ((r_state == ST_HDR) ? (r_idx == 3'd3) : (r_idx == 3'd5));

    assign w_data = r_buf;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        in_ready     = 1'b0;
        wr_en        = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next_state = (cmd_length != 8'd0) ? ST_HDR : ST_PUSH;
                end
            end
            ST_HDR, ST_DATA: begin
                in_ready = 1'b1;
                if (in_valid && w_last_byte) begin
                    w_next_state = ST_PUSH;
                end
            end
            ST_PUSH: begin
                // The strobe is gated by the live full flag so a write is never lost to a full FIFO.
                if (!f_full) begin
                    wr_en        = 1'b1;
                    w_next_state = (r_rem != 8'd0) ? ST_DATA : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_rem <= 8'd0;
            r_idx <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_buf <= {cmd_cfg_sel, cmd_slv_id, cmd_length, 32'h0000_0000};
                        r_rem <= cmd_length;
                        r_idx <= 3'd0;
                    end
                end
                ST_HDR, ST_DATA: begin
                    if (in_valid) begin
                        r_buf[w_base -: 8] <= in_byte;
                        r_rem              <= r_rem - 8'd1;
                        r_idx              <= r_idx + 3'd1;
                    end
                end
                ST_PUSH: begin
                    // Clearing on the write gives the next continuation frame its zero padding.
                    if (!f_full) begin
                        r_buf <= '0;
                        r_idx <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_encoder.sv
// Directed bench for apb_encoder: drives inputs 1 time unit after the rising edge,
// samples on the falling edge, and logs every FIFO write into a queue.
module tb_apb_encoder;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_cfg_sel;
    logic [6:0]  cmd_slv_id;
    logic [7:0]  cmd_length;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        f_full;
    logic        wr_en;
    logic [47:0] w_data;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          viol    = 0;
    logic        prev_wr = 1'b0;
    logic [47:0] wq[$];
    logic [7:0]  stim[0:15];
    int          stream_cycles;
    logic        first_rdy;

    apb_encoder #(.RAH_PACKET_WIDTH(48)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_cfg_sel (cmd_cfg_sel),
        .cmd_slv_id  (cmd_slv_id),
        .cmd_length  (cmd_length),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .f_full      (f_full),
        .wr_en       (wr_en),
        .w_data      (w_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Write logger plus the two strobe rules: never while full, never back to back.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq.push_back(w_data);
            if (f_full) viol++;
            if (prev_wr) viol++;
        end
        prev_wr = (wr_en === 1'b1);
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) stim[i] = first + 8'(i);
    endtask

    task automatic send_cmd(input logic cfg, input logic [6:0] slv, input logic [7:0] len);
        cmd_valid   = 1'b1;
        cmd_cfg_sel = cfg;
        cmd_slv_id  = slv;
        cmd_length  = len;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_bytes(input int start, input int n);
        int i   = start;
        int cnt = 0;
        while (i < start + n && cnt < 200) begin
            in_valid = 1'b1;
            in_byte  = stim[i];
            @(negedge clk);
            if (cnt == 0) first_rdy = in_ready;
            if (in_ready) i++;
            cnt++;
            tick();
        end
        in_valid      = 1'b0;
        stream_cycles = cnt;
        check("stream_done", 48'(i), 48'(start + n));
    endtask

    task automatic wait_idle();
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < 100);
        check("idle_reached", busy, 1'b0);
        tick();
    endtask

    initial begin
        int          bad;
        logic [47:0] hold;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_cfg_sel = 1'b0; cmd_slv_id = 7'h0;
        cmd_length = 8'h0; in_valid = 1'b0; in_byte = 8'h0; f_full = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_w_data", w_data, 48'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        // Zero-length command: write in the cycle right after accept, then idle.
        send_cmd(1'b1, 7'h05, 8'd0);
        @(negedge clk);
        check("l0_wr_en", wr_en, 1'b1);
        check("l0_w_data", w_data, 48'h85_00_0000_0000);
        check("l0_busy", busy, 1'b1);
        tick();
        @(negedge clk);
        check("l0_busy_drop", busy, 1'b0);
        tick();
        check("l0_count", 48'(wq.size()), 48'd1);
        wq.delete();

        // Short transfer, header only.
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
        send_cmd(1'b0, 7'h12, 8'd3);
        send_bytes(0, 3);
        check("l3_first_in_ready", first_rdy, 1'b1);
        wait_idle();
        check("l3_count", 48'(wq.size()), 48'd1);
        check("l3_word", wq[0], 48'h12_03_AABB_CC00);
        wq.delete();

        // One continuation frame.
        load_seq(8'h01, 10);
        send_cmd(1'b1, 7'h33, 8'd10);
        send_bytes(0, 10);
        check("l10_cycles", 48'(stream_cycles), 48'd11);
        wait_idle();
        check("l10_count", 48'(wq.size()), 48'd2);
        check("l10_hdr", wq[0], 48'hB3_0A_0102_0304);
        check("l10_cont", wq[1], 48'h0506_0708_090A);
        wq.delete();

        // Padded last frame, and extra bytes are refused.
        load_seq(8'h01, 11);
        send_cmd(1'b0, 7'h01, 8'd11);
        send_bytes(0, 11);
        check("l11_cycles", 48'(stream_cycles), 48'd13);
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (in_ready) bad++;
            tick();
        end
        in_valid = 1'b0;
        check("l11_no_extra_ready", 48'(bad), 48'd0);
        wait_idle();
        check("l11_count", 48'(wq.size()), 48'd3);
        check("l11_hdr", wq[0], 48'h01_0B_0102_0304);
        check("l11_mid", wq[1], 48'h0506_0708_090A);
        check("l11_pad", wq[2], 48'h0B00_0000_0000);
        wq.delete();

        // Backpressure on the header push for 5 cycles.
        load_seq(8'h01, 10);
        f_full = 1'b1;
        send_cmd(1'b1, 7'h33, 8'd10);
        send_bytes(0, 4);
        @(negedge clk);
        hold = w_data;
        check("bp_stall_data", hold, 48'hB3_0A_0102_0304);
        bad = (wr_en !== 1'b0) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            if (wr_en !== 1'b0 || w_data !== hold) bad++;
        end
        check("bp_stall_quiet", 48'(bad), 48'd0);
        tick();
        f_full = 1'b0;
        @(negedge clk);
        check("bp_release_wr_en", wr_en, 1'b1);
        check("bp_release_data", w_data, 48'hB3_0A_0102_0304);
        tick();
        send_bytes(4, 6);
        wait_idle();
        check("bp_count", 48'(wq.size()), 48'd2);
        check("bp_cont", wq[1], 48'h0506_0708_090A);
        wq.delete();

        // Reset in the middle of a header frame.
        load_seq(8'h01, 10);
        send_cmd(1'b0, 7'h12, 8'd10);
        send_bytes(0, 2);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_w_data", w_data, 48'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_write", 48'(wq.size()), 48'd0);
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
        send_cmd(1'b1, 7'h7F, 8'd3);
        send_bytes(0, 3);
        wait_idle();
        check("post_rst_count", 48'(wq.size()), 48'd1);
        check("post_rst_word", wq[0], 48'hFF_03_1122_3300);

        check("strobe_rules", 48'(viol), 48'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
